// File: rtl/evt_pkg.sv
// Shared types for the multi-channel event counter.
package evt_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } count_mode_e;

endpackage

// File: rtl/evt_counter_ch.sv
// One counter channel: count, sticky overflow, wrap pulse and edge history.
module evt_counter_ch
    import evt_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_COUNT = 65536,
    parameter bit EDGE_EVT  = 1'b0
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             en_i,
    input  count_mode_e      mode_i,
    input  logic             evt_i,
    input  logic             clr_i,
    input  logic             snap_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o,
    output logic             ovf_o
);

    localparam logic [WIDTH-1:0] TOP_V = WIDTH'(MAX_COUNT - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             wrap_q, wrap_d;
    logic             evt_q;
    logic             hit;

    // Edge history resets high so a line already asserted at release is not an edge.
    assign hit = en_i & evt_i & (EDGE_EVT ? ~evt_q : 1'b1);

    always_comb begin
        count_d = count_q;
        ovf_d   = snap_i ? 1'b0 : ovf_q;
        wrap_d  = 1'b0;
        if (clr_i) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (hit) begin
            if (count_q != TOP_V) begin
                count_d = count_q + 1'b1;
            end else begin
                // Overflow set wins over a simultaneous snapshot read-and-clear.
                ovf_d = 1'b1;
                if (mode_i == CNT_WRAP) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            wrap_q  <= 1'b0;
            evt_q   <= 1'b1;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            wrap_q  <= wrap_d;
            evt_q   <= evt_i;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = wrap_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/multi_evt_counter.sv
// Multi-channel event counter with atomic all-channel snapshot.
module multi_evt_counter
    import evt_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int WIDTH     = 16,
    parameter int MAX_COUNT = 65536,
    parameter bit EDGE_EVT  = 1'b0
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         en_in,
    input  logic                         mode_in,
    input  logic [NUM_CH-1:0]            evt_in,
    input  logic [NUM_CH-1:0]            clr_in,
    input  logic                         snap_in,
    output logic [NUM_CH-1:0][WIDTH-1:0] count_out,
    output logic [NUM_CH-1:0]            wrap_out,
    output logic [NUM_CH-1:0]            ovf_out,
    output logic [NUM_CH-1:0][WIDTH-1:0] snap_count_out,
    output logic [NUM_CH-1:0]            snap_ovf_out,
    output logic                         snap_valid_out
);

    localparam longint unsigned MAXC  = longint'(MAX_COUNT);
    localparam longint unsigned RANGE = 64'd1 << WIDTH;

    if (NUM_CH < 1 || MAX_COUNT < 2 || MAXC > RANGE) begin : g_bad_param
        $error("multi_evt_counter: need NUM_CH>=1 and 2 <= MAX_COUNT <= 2**WIDTH");
    end

    count_mode_e mode;
    assign mode = count_mode_e'(mode_in);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        evt_counter_ch #(
            .WIDTH     (WIDTH),
            .MAX_COUNT (MAX_COUNT),
            .EDGE_EVT  (EDGE_EVT)
        ) u_ch (
            .clk_in   (clk_in),
            .rst_n_in (rst_n_in),
            .en_i     (en_in),
            .mode_i   (mode),
            .evt_i    (evt_in[i]),
            .clr_i    (clr_in[i]),
            .snap_i   (snap_in),
            .count_o  (count_out[i]),
            .wrap_o   (wrap_out[i]),
            .ovf_o    (ovf_out[i])
        );
    end

    logic [NUM_CH-1:0][WIDTH-1:0] snap_count_q;
    logic [NUM_CH-1:0]            snap_ovf_q;
    logic                         snap_valid_q;

    // Snapshot takes the registered (pre-update) values seen at the snap edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            snap_count_q <= '0;
            snap_ovf_q   <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            snap_valid_q <= snap_in;
            if (snap_in) begin
                snap_count_q <= count_out;
                snap_ovf_q   <= ovf_out;
            end
        end
    end

    assign snap_count_out = snap_count_q;
    assign snap_ovf_out   = snap_ovf_q;
    assign snap_valid_out = snap_valid_q;

endmodule

// File: tb/tb_multi_evt_counter.sv
// Randomized bench: level-mode (mod 10) and edge-mode (mod 16) instances vs a behavioural model.
module tb_multi_evt_counter;

    localparam int NCH = 4;
    localparam int W   = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic en, mode, snap;
    logic [NCH-1:0] evt, clr;

    logic [NCH-1:0][W-1:0] cnt_a, scnt_a, cnt_b, scnt_b;
    logic [NCH-1:0] wrap_a, ovf_a, sovf_a, wrap_b, ovf_b, sovf_b;
    logic sv_a, sv_b;

    always #5 clk = ~clk;

    multi_evt_counter #(.NUM_CH(NCH), .WIDTH(W), .MAX_COUNT(10), .EDGE_EVT(1'b0)) u_lvl (
        .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .mode_in(mode), .evt_in(evt),
        .clr_in(clr), .snap_in(snap), .count_out(cnt_a), .wrap_out(wrap_a),
        .ovf_out(ovf_a), .snap_count_out(scnt_a), .snap_ovf_out(sovf_a),
        .snap_valid_out(sv_a));

    multi_evt_counter #(.NUM_CH(NCH), .WIDTH(W), .MAX_COUNT(16), .EDGE_EVT(1'b1)) u_edg (
        .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .mode_in(mode), .evt_in(evt),
        .clr_in(clr), .snap_in(snap), .count_out(cnt_b), .wrap_out(wrap_b),
        .ovf_out(ovf_b), .snap_count_out(scnt_b), .snap_ovf_out(sovf_b),
        .snap_valid_out(sv_b));

    // Model: [0] = level mode mod 10, [1] = edge mode mod 16.
    int     m_max [2] = '{10, 16};
    bit     m_edge[2] = '{1'b0, 1'b1};
    int     m_cnt [2][NCH];
    bit     m_ovf [2][NCH];
    bit     m_wrap[2][NCH];
    bit     m_hist[2][NCH];
    int     m_scnt[2][NCH];
    bit     m_sovf[2][NCH];
    bit     m_sv  [2];

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sv[k] = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_cnt[k][i] = 0; m_ovf[k][i] = 0; m_wrap[k][i] = 0;
                m_hist[k][i] = 1; m_scnt[k][i] = 0; m_sovf[k][i] = 0;
            end
        end
    endfunction

    function automatic void model_clock();
        for (int k = 0; k < 2; k++) begin
            m_sv[k] = snap;
            for (int i = 0; i < NCH; i++) begin
                bit hit;
                hit = en && evt[i] && (!m_edge[k] || !m_hist[k][i]);
                if (snap) begin
                    m_scnt[k][i] = m_cnt[k][i];
                    m_sovf[k][i] = m_ovf[k][i];
                end
                m_wrap[k][i] = 0;
                if (clr[i]) begin
                    m_cnt[k][i] = 0;
                    m_ovf[k][i] = 0;
                end else begin
                    if (snap) m_ovf[k][i] = 0;
                    if (hit) begin
                        if (m_cnt[k][i] < m_max[k] - 1) m_cnt[k][i]++;
                        else begin
                            m_ovf[k][i] = 1;
                            if (!mode) begin
                                m_cnt[k][i] = 0;
                                m_wrap[k][i] = 1;
                            end
                        end
                    end
                end
                m_hist[k][i] = evt[i];
            end
        end
    endfunction

    task automatic check_all(input string ph);
        logic [15:0] ec [2];
        logic [15:0] es [2];
        logic [3:0]  ew [2];
        logic [3:0]  eo [2];
        logic [3:0]  eso[2];
        for (int k = 0; k < 2; k++) begin
            ec[k] = '0; es[k] = '0; ew[k] = '0; eo[k] = '0; eso[k] = '0;
            for (int i = 0; i < NCH; i++) begin
                ec[k][i*W +: W] = W'(m_cnt[k][i]);
                es[k][i*W +: W] = W'(m_scnt[k][i]);
                ew[k][i] = m_wrap[k][i];
                eo[k][i] = m_ovf[k][i];
                eso[k][i] = m_sovf[k][i];
            end
        end
        chk({ph, " lvl count"}, 32'(cnt_a), 32'(ec[0]));
        chk({ph, " lvl wrap"}, 32'(wrap_a), 32'(ew[0]));
        chk({ph, " lvl ovf"}, 32'(ovf_a), 32'(eo[0]));
        chk({ph, " lvl snap_count"}, 32'(scnt_a), 32'(es[0]));
        chk({ph, " lvl snap_ovf"}, 32'(sovf_a), 32'(eso[0]));
        chk({ph, " lvl snap_valid"}, 32'(sv_a), 32'(m_sv[0]));
        chk({ph, " edg count"}, 32'(cnt_b), 32'(ec[1]));
        chk({ph, " edg wrap"}, 32'(wrap_b), 32'(ew[1]));
        chk({ph, " edg ovf"}, 32'(ovf_b), 32'(eo[1]));
        chk({ph, " edg snap_count"}, 32'(scnt_b), 32'(es[1]));
        chk({ph, " edg snap_ovf"}, 32'(sovf_b), 32'(eso[1]));
        chk({ph, " edg snap_valid"}, 32'(sv_b), 32'(m_sv[1]));
    endtask

    task automatic cyc(input string ph);
        @(posedge clk);
        model_clock();
        #1;
        check_all(ph);
    endtask

    task automatic idle();
        en = 1'b1; mode = 1'b0; snap = 1'b0; evt = '0; clr = '0;
    endtask

    task automatic async_reset(input string ph);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(ph);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        evt = 4'b0001;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Drive ch0 to 7, then reset asynchronously with no edge
        for (int c = 0; c < 7; c++) cyc("pre_reset");
        chk("pre_reset ch0=7", 32'(cnt_a[0]), 32'd7);
        async_reset("mid_reset");

        // Wrap: ch0 held high 12 cycles -> 1..9,0,1,2
        idle(); evt = 4'b0001;
        for (int c = 0; c < 12; c++) cyc("wrap");
        chk("wrap ch0 final", 32'(cnt_a[0]), 32'd2);
        chk("wrap ch0 ovf", 32'(ovf_a[0]), 32'd1);

        // Saturate on ch1, then switch to wrap
        idle(); mode = 1'b1; evt = 4'b0010;
        for (int c = 0; c < 15; c++) cyc("sat");
        chk("sat ch1 held", 32'(cnt_a[1]), 32'd9);
        mode = 1'b0;
        cyc("sat_to_wrap");
        chk("sat_to_wrap ch1", 32'(cnt_a[1]), 32'd0);
        chk("sat_to_wrap pulse", 32'(wrap_a[1]), 32'd1);

        // Clear beats hit on ch2
        idle(); evt = 4'b0100;
        for (int c = 0; c < 5; c++) cyc("clr_setup");
        clr = 4'b0100;
        cyc("clr_prio");
        chk("clr_prio ch2", 32'(cnt_a[2]), 32'd0);

        // Snapshot with hit on ch0; ch3 saturated with ovf
        idle(); clr = 4'b1001;
        cyc("snap_setup");
        clr = '0; evt = 4'b1000; mode = 1'b1;
        for (int c = 0; c < 11; c++) cyc("snap_setup");
        evt = 4'b0001;
        for (int c = 0; c < 3; c++) cyc("snap_setup");
        snap = 1'b1;
        cyc("snap");
        chk("snap ch0", 32'(scnt_a[0]), 32'd3);
        chk("snap ch3", 32'(scnt_a[3]), 32'd9);
        chk("snap ovf3 cleared", 32'(ovf_a[3]), 32'd0);

        // Pending snap_valid killed by async reset
        idle(); snap = 1'b1;
        cyc("snap_pending");
        async_reset("reset_kills_valid");

        // Edge instance: evt high across release, then 0,1,1,1,0,1 with en=0 on one edge
        idle(); evt = 4'b1111;
        cyc("edge_held");
        evt = 4'b0000; cyc("edge_pat");
        evt = 4'b1111; cyc("edge_pat");
        cyc("edge_pat"); cyc("edge_pat");
        evt = 4'b0000; cyc("edge_pat");
        evt = 4'b1111; cyc("edge_pat");
        chk("edge count", 32'(cnt_b[0]), 32'd2);
        evt = 4'b0000; cyc("edge_en");
        en = 1'b0; evt = 4'b1111; cyc("edge_en");
        en = 1'b1; cyc("edge_en");
        chk("edge disabled", 32'(cnt_b[0]), 32'd2);

        // Full-width wrap on edge instance: toggle for 16+ edges
        idle();
        for (int c = 0; c < 40; c++) begin
            evt = (c % 2) ? 4'b1111 : 4'b0000;
            cyc("full_width");
        end

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            en   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            evt  = 4'($urandom);
            clr  = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0;
            snap = ($urandom_range(0, 14) == 0) || (c > 1500 && c < 1510);
            cyc("random");
            if (c == 2000) async_reset("random_reset");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multi_evt_counter.md
Name: multi_evt_counter

Overview:
Parametrised multi-channel event counter; next generation of the single-channel evt_counter. Each channel counts its own event line up to MAX_COUNT-1, in wrap or saturate mode, with level or rising-edge event qualification, per-channel clear, sticky overflow flags and an atomic all-channel snapshot. Used for statistics and throughput monitoring, e.g. per-microphone sample-valid counts and frame counters, read by the debug/UART path.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
WIDTH, 16, counter width in bits
MAX_COUNT, 65536, counter modulus; legal counts 0..MAX_COUNT-1; elaboration error unless 2 <= MAX_COUNT <= 2**WIDTH
EDGE_EVT, 0, 0 = count every cycle evt_in is high; 1 = count rising edges of evt_in only

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
en_in  input  1  global count enable; when low, events are ignored
mode_in  input  1  0 = wrap, 1 = saturate; sampled every cycle
evt_in  input  NUM_CH  per-channel event
clr_in  input  NUM_CH  per-channel synchronous clear of count and sticky flag
snap_in  input  1  capture all counts and flags
count_out  output  NUM_CH x WIDTH  live counts
wrap_out  output  NUM_CH  1-cycle pulse when a channel wraps
ovf_out  output  NUM_CH  sticky overflow flag
snap_count_out  output  NUM_CH x WIDTH  snapshot counts
snap_ovf_out  output  NUM_CH  snapshot of ovf_out
snap_valid_out  output  1  1-cycle pulse, snapshot registers updated

Behaviour:
- One clock, clk_in. Reset rst_n_in is asynchronous and active-low. While low, all outputs are 0 and the edge-detect history regs are 1. A line already high when reset releases is therefore not an edge.
- Qualified event hit[i]: en_in & evt_in[i] if EDGE_EVT=0; en_in & evt_in[i] & ~evt_q[i] if EDGE_EVT=1. evt_q[i] is evt_in[i] registered every cycle, regardless of en_in.
- Latency: count_out reflects a hit at the same clock edge it is sampled on, so it is visible the next cycle. No further pipeline.
- Per channel, in priority order:
  1. clr_in[i]: count <- 0, ovf <- 0. Clear beats a simultaneous hit, so the result is 0, not 1.
  2. hit and count < MAX_COUNT-1: count <- count+1.
  3. hit and count == MAX_COUNT-1, wrap mode: count <- 0, wrap_out[i] pulses for 1 cycle, ovf <- 1.
  4. hit and count == MAX_COUNT-1, saturate mode: count holds, ovf <- 1, no wrap_out.
  5. otherwise: hold.
- wrap_out is registered and asserts the cycle count_out shows 0.
- Snapshot: on a cycle with snap_in=1, snap_count_out and snap_ovf_out load the pre-update values (count_out/ovf_out as registered at that edge). snap_valid_out=1 the following cycle.
  - Sticky ovf of every channel not being cleared is reset to 0 by the snapshot (read-and-clear).
  - If an overflow occurs in the same cycle as snap_in, the set wins: ovf=1 after the edge, and the snapshot shows the old value.
  - Back-to-back snap_in produces one snapshot and one valid pulse per cycle.
- mode_in change takes effect on the next hit. A counter at MAX_COUNT-1 in saturate mode wraps on the first hit after switching to wrap.
- Counts never exceed MAX_COUNT-1 and are never negative. Arithmetic is unsigned WIDTH bits.
- Reset mid-operation clears everything immediately (asynchronously), including any pending snap_valid_out.

Decomposition:
- Package evt_pkg: typedef count_mode_e {CNT_WRAP=0, CNT_SAT=1}; typedef for count width is derived from the parameter in the module.
- Sub-module evt_counter_ch: one channel holding count, ovf, wrap and edge history. Instantiated NUM_CH times in a generate loop.
- Top level holds the shared snapshot registers and snap_valid_out.

Test Plan:
(NUM_CH=4, WIDTH=4, MAX_COUNT=10 unless noted)
1. Reset: assert rst_n_in mid-count at count 7 with no clock edge -> all outputs 0 immediately. After release, hold evt_in[0]=1 for 12 cycles in wrap mode -> counts 1..9,0,1,2; wrap_out[0] pulses once, on the cycle count reads 0; ovf_out[0]=1.
2. Saturate: mode_in=1, 15 hits on ch1 -> count_out[1] stops at 9, ovf_out[1]=1, wrap_out[1] never asserts. Switch mode_in=0, one hit -> count 0, wrap pulse.
3. Clear priority: ch2 at 5, clr_in[2]=1 and evt_in[2]=1 in the same cycle -> count 0, ovf 0. Channels 0, 1 and 3 are unaffected.
4. Snapshot: ch0=3, ch3=9 with ovf=1; snap_in plus a hit on ch0 in the same cycle -> snap_count_out shows 3 and 9, snap_ovf_out[3]=1, snap_valid_out high the next cycle; live ch0=4; ovf_out[3]=0 afterwards.
5. Edge mode (EDGE_EVT=1): evt_in[0] held high across reset release, then a pattern of 0,1,1,1,0,1 -> count 2. With en_in=0 during one edge -> that edge is not counted.
6. Full width (WIDTH=4, MAX_COUNT=16): 16 hits -> count wraps 15 -> 0, no X or out-of-range values. Elaboration with MAX_COUNT=17 fails.
